// File: rtl/dac_segment_encoder_pkg.sv
// Shared sizes, pointer type and modulo-17 pointer arithmetic for the
// segmented DAC encoder.
package dac_seg_pkg;

   localparam int CODE_W  = 10;
   localparam int N_THERM = 17;
   localparam int N_BIN   = 6;

   typedef logic [4:0] ptr_t;

   // ptr <= 16 and k <= 15 keep the raw sum within 31, so one subtract is enough.
   function automatic ptr_t ptr_add_mod17(input ptr_t ptr, input logic [3:0] k);
      ptr_t sum;
      sum = ptr + {1'b0, k};
      if (sum >= 5'd17) begin
         sum = sum - 5'd17;
      end
      return sum;
   endfunction

endpackage

// File: rtl/dac_therm_rotator.sv
// Combinational unit-cell mask: k ones starting at ptr (rotated modulo N_THERM),
// or starting at cell 0 when rotation is disabled.
module dac_therm_rotator #(
   parameter int N_THERM = dac_seg_pkg::N_THERM
) (
   input  logic [3:0]         k_i,
   input  logic [4:0]         ptr_i,
   input  logic               dem_en_i,
   output logic [N_THERM-1:0] mask_o
);
   import dac_seg_pkg::*;

   logic [N_THERM-1:0]   base;
   ptr_t                 shift;
   logic [2*N_THERM-1:0] dbl;

   always_comb begin
      base   = (N_THERM'(1) << k_i) - N_THERM'(1);
      shift  = dem_en_i ? ptr_i : '0;
      // Bits pushed past the top fold back onto the low cells.
      dbl    = {{N_THERM{1'b0}}, base} << shift;
      mask_o = dbl[N_THERM-1:0] | dbl[2*N_THERM-1:N_THERM];
   end

endmodule

// File: rtl/dac_segment_encoder.sv
// Two-stage segmented DAC encoder: thermometer MSBs with optional rotation,
// binary LSBs. Define DAC_LSB_SWAP_EN to alternate the LSB onto the redundant cell.
module dac_segment_encoder #(
   parameter int CODE_W  = dac_seg_pkg::CODE_W,
   parameter int N_THERM = dac_seg_pkg::N_THERM,
   parameter int N_BIN   = dac_seg_pkg::N_BIN
) (
   input  logic               clkin,
   input  logic               pdb,
   input  logic [CODE_W-1:0]  code_in,
   input  logic               code_valid,
   input  logic               dem_en,
   output logic [N_THERM-1:0] therm_out,
   output logic [N_BIN-1:0]   bin_out,
   output logic               bin_red_out,
   output logic               out_valid,
   output logic [4:0]         ptr_dbg
);
   import dac_seg_pkg::*;

   logic [CODE_W-1:0]  code_q;
   logic               dem_q;
   logic               v1_q;

   logic [N_THERM-1:0] therm_q, therm_d;
   logic [N_BIN-1:0]   bin_q, bin_d;
   logic               valid_q, valid_d;
   ptr_t               ptr_q, ptr_d;

   logic [3:0]         k;
   logic [N_BIN-1:0]   bin;
   logic [N_THERM-1:0] mask;

   assign k   = code_q[N_BIN +: 4];
   assign bin = code_q[N_BIN-1:0];

   dac_therm_rotator #(.N_THERM(N_THERM)) u_rot (
      .k_i      (k),
      .ptr_i    (ptr_q),
      .dem_en_i (dem_q),
      .mask_o   (mask)
   );

   always_ff @(posedge clkin) begin
      if (!pdb) begin
         code_q <= '0;
         dem_q  <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         v1_q <= code_valid;
         if (code_valid) begin
            code_q <= code_in;
            dem_q  <= dem_en;
         end
      end
   end

`ifdef DAC_LSB_SWAP_EN
   logic swap_q, swap_d;
   logic red_q, red_d;
`endif

   always_comb begin
      therm_d = therm_q;
      bin_d   = bin_q;
      valid_d = 1'b0;
      ptr_d   = ptr_q;
`ifdef DAC_LSB_SWAP_EN
      swap_d  = swap_q;
      red_d   = red_q;
`endif
      if (v1_q) begin
         valid_d = 1'b1;
         therm_d = mask;
         if (dem_q) begin
            ptr_d = ptr_add_mod17(ptr_q, k);
         end
`ifdef DAC_LSB_SWAP_EN
         if (swap_q) begin
            bin_d = {bin[N_BIN-1:1], 1'b0};
            red_d = bin[0];
         end else begin
            bin_d = bin;
            red_d = 1'b0;
         end
         swap_d = ~swap_q;
`else
         bin_d = bin;
`endif
      end
   end

   always_ff @(posedge clkin) begin
      if (!pdb) begin
         therm_q <= '0;
         bin_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
`ifdef DAC_LSB_SWAP_EN
         swap_q  <= 1'b0;
         red_q   <= 1'b0;
`endif
      end else begin
         therm_q <= therm_d;
         bin_q   <= bin_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
`ifdef DAC_LSB_SWAP_EN
         swap_q  <= swap_d;
         red_q   <= red_d;
`endif
      end
   end

   assign therm_out = therm_q;
   assign bin_out   = bin_q;
   assign out_valid = valid_q;
   assign ptr_dbg   = ptr_q;
`ifdef DAC_LSB_SWAP_EN
   assign bin_red_out = red_q;
`else
   assign bin_red_out = 1'b0;
`endif

endmodule

// File: doc/dac_segment_encoder.md
DAC_SEGMENT_ENCODER -- requirements
Module: dac_segment_encoder

Interface
REQ-001 SHALL have parameter CODE_W, default 10: input code width.
REQ-002 SHALL have parameter N_THERM, default 17: thermometer unit cells, driving clkout_therm_16..0 domains.
REQ-003 SHALL have parameter N_BIN, default 6: binary cells, driving clkout_binary_5..0 domains.
REQ-004 SHALL have port clkin, in, 1: single clock, the distributed DAC clock.
REQ-005 SHALL have port pdb, in, 1: reset, synchronous and active-low.
REQ-006 SHALL have port code_in, in, CODE_W: unsigned sample.
REQ-007 SHALL have port code_valid, in, 1: code_in is valid this cycle.
REQ-008 SHALL have port dem_en, in, 1: rotation (DEM) enable.
REQ-009 SHALL have port therm_out, out, N_THERM: unit-cell enables, bit i drives cell i.
REQ-010 SHALL have port bin_out, out, N_BIN: binary-cell enables.
REQ-011 SHALL have port bin_red_out, out, 1: redundant-LSB cell enable.
REQ-012 SHALL have port out_valid, out, 1: outputs carry a new sample.
REQ-013 SHALL have port ptr_dbg, out, 5: current rotation pointer.

Function
REQ-014 SHALL form a 2-stage pipeline: stage 1 registers code_in on code_valid; stage 2 registers the decoded outputs; out_valid rises exactly 2 cycles after code_valid and lasts 1 cycle per sample.
REQ-015 SHALL hold therm_out, bin_out and bin_red_out at their last values when no sample completes, with out_valid=0.
REQ-016 SHALL compute k = code[9:6] (range 0..15) and bin = code[5:0].
REQ-017 SHALL, with dem_en=0, set therm_out bits 0..k-1 to 1 and all other bits to 0.
REQ-018 SHALL, with dem_en=1, set therm_out bits ptr..ptr+k-1 modulo 17, using the pre-update ptr.
REQ-019 SHALL, in the cycle each stage-2 sample is registered with dem_en=1, update ptr to (ptr+k) mod 17 via a 5-bit add with conditional subtract of 17 (maximum intermediate value 31).
REQ-020 SHALL leave ptr unchanged when k=0 and on any sample taken with dem_en=0; clearing dem_en SHALL hold ptr, not reset it.
REQ-021 SHALL process back-to-back code_valid samples at full rate, one sample per cycle.
REQ-022 SHALL take the dem_en value sampled with the sample in stage 1 as the mode for that sample; toggling dem_en mid-stream affects only later samples.

Reset
REQ-023 SHALL, with pdb=0 at a clkin edge, clear therm_out, bin_out, bin_red_out, out_valid, ptr, swap phase and all pipeline valids to 0.
REQ-024 SHALL discard samples in flight when pdb is asserted mid-operation; no out_valid is produced for them.

Configuration
REQ-025 SHALL, with DAC_LSB_SWAP_EN defined, toggle a swap phase on each output sample; in phase 1 bin[0] SHALL drive bin_red_out and bin_out[0] SHALL be 0; in phase 0 bin_out[0]=bin[0] and bin_red_out=0.
REQ-026 SHALL, without DAC_LSB_SWAP_EN, tie bin_red_out to 0, pass bin_out=bin, and omit the swap-phase flop.

Structure
REQ-027 SHALL place CODE_W, N_THERM, N_BIN, typedef ptr_t (5-bit) and function ptr_add_mod17 in package dac_seg_pkg.
REQ-028 SHALL use one combinational sub-module, dac_therm_rotator (inputs k, ptr, dem_en; output is the N_THERM mask).

Verification
REQ-029 SHALL verify reset: pdb=0 for 2 cycles -> all outputs 0, ptr_dbg=0.
REQ-030 SHALL verify no-DEM decode: dem_en=0, code 10'h2A5 -> 2 cycles later therm_out=17'h003FF, bin_out=6'h25, out_valid pulses 1 cycle.
REQ-031 SHALL verify rotation wrap: dem_en=1, ptr=0, two back-to-back codes with k=10 -> therm_out=17'h003FF then 17'h1FC07; ptr_dbg goes 10 then 3.
REQ-032 SHALL verify zero code: k=0, bin=0 -> therm_out=0, bin_out=0, ptr_dbg unchanged.
REQ-033 SHALL verify mid-operation reset: pdb=0 one cycle after code_valid -> out_valid never asserts, ptr_dbg=0.
REQ-034 SHALL verify the macro: with DAC_LSB_SWAP_EN, two samples with bin=6'h01 -> bin_out=6'h01/bin_red_out=0, then bin_out=6'h00/bin_red_out=1.
